// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: merges the instruction-fetch and data sram-like ports onto one
// downstream sram-like bus, one transaction in flight, with cancelled-fetch response drop.
`default_nettype none

module sram_bus_arbiter #(
    parameter int PRIO_DATA = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   owner;       // 1 = data port owns the transaction
    logic   last_grant;  // 1 = data port received the most recent addr_ok
    logic   drop;

    logic any_req;
    logic grant;
    logic sel;
    logic accept;
    logic resp;
    logic cancel_hit;

    always_comb begin
        any_req = inst_req | data_req;
        if (inst_req && data_req)
            grant = (PRIO_DATA != 0) ? 1'b1 : ~last_grant;
        else
            grant = data_req;

        sel     = (state == IDLE) ? grant : owner;
        bus_req = (state == IDLE) ? any_req : (state == ADDR);
        accept  = bus_req & bus_addr_ok;
        resp    = (state == DATA) & bus_data_ok;

        // A fetch is killable from the cycle it is granted until its response.
        cancel_hit = inst_cancel & ((state == IDLE) ? (any_req & ~grant) : ~owner);

        inst_addr_ok = accept & ~sel;
        data_addr_ok = accept & sel;
        inst_data_ok = resp & ~owner & ~drop & ~inst_cancel;
        data_data_ok = resp & owner;

        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_addr  = 32'd0;
        bus_wstrb = 4'd0;
        bus_wdata = 32'd0;
        if (bus_req) begin
            bus_wr    = sel ? data_wr    : inst_wr;
            bus_size  = sel ? data_size  : inst_size;
            bus_addr  = sel ? data_addr  : inst_addr;
            bus_wstrb = sel ? data_wstrb : inst_wstrb;
            bus_wdata = sel ? data_wdata : inst_wdata;
        end
    end

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            drop       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= grant;
                        state <= bus_addr_ok ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    if (bus_addr_ok)
                        state <= DATA;
                end
                DATA: begin
                    if (bus_data_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept)
                last_grant <= sel;

            if (resp)
                drop <= 1'b0;
            else if (cancel_hit)
                drop <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: table-driven scoreboard bench; two instances (fixed priority and
// round-robin) share stimulus, each row selects which instance's outputs are compared.
`default_nettype none

module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req, inst_cancel;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    localparam logic [31:0] IADDR = 32'h1C00_0000;
    localparam logic [31:0] DADDR = 32'h0000_1000;
    localparam logic [31:0] DWDAT = 32'hDEAD_BEEF;
    localparam logic [31:0] RDAT  = 32'h0280_0404;

    logic        p_iaok[2], p_idok[2], p_daok[2], p_ddok[2];
    logic [31:0] p_ird[2], p_drd[2];
    logic        p_breq[2], p_bwr[2], p_busy[2];
    logic [1:0]  p_bsz[2];
    logic [31:0] p_badr[2], p_bwd[2];
    logic [3:0]  p_bws[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_bus_arbiter #(.PRIO_DATA(1 - g)) dut (
            .clk(clk), .resetn(resetn),
            .inst_req(inst_req), .inst_wr(1'b0), .inst_size(2'd2), .inst_addr(IADDR),
            .inst_wstrb(4'h0), .inst_wdata(32'h0),
            .inst_addr_ok(p_iaok[g]), .inst_data_ok(p_idok[g]), .inst_rdata(p_ird[g]),
            .inst_cancel(inst_cancel),
            .data_req(data_req), .data_wr(1'b1), .data_size(2'd2), .data_addr(DADDR),
            .data_wstrb(4'hF), .data_wdata(DWDAT),
            .data_addr_ok(p_daok[g]), .data_data_ok(p_ddok[g]), .data_rdata(p_drd[g]),
            .bus_req(p_breq[g]), .bus_wr(p_bwr[g]), .bus_size(p_bsz[g]), .bus_addr(p_badr[g]),
            .bus_wstrb(p_bws[g]), .bus_wdata(p_bwd[g]),
            .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
            .busy(p_busy[g])
        );
    end

    typedef struct {
        string       name;
        logic        rst, ir, dr, cn, ao, dk, rr;
        logic [3:0]  oks;    // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
        logic        breq;
        logic [31:0] addr;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input string nm, input logic rst, ir, dr, cn, ao, dk, rr,
                                input logic [3:0] oks, input logic breq,
                                input logic [31:0] addr, input logic busy);
        vec_t v;
        v.name = nm; v.rst = rst; v.ir = ir; v.dr = dr; v.cn = cn; v.ao = ao; v.dk = dk;
        v.rr = rr; v.oks = oks; v.breq = breq; v.addr = addr; v.busy = busy;
        return v;
    endfunction

    task automatic compare(input vec_t e);
        int          k;
        logic [38:0] act, exp;
        logic [38:0] fact, fexp;
        logic [31:0] rd_act, rd_exp;
        k = e.rr ? 1 : 0;
        act = {p_iaok[k], p_daok[k], p_idok[k], p_ddok[k], p_breq[k], p_busy[k],
               1'b0, p_badr[k]};
        exp = {e.oks, e.breq, e.busy, 1'b0, e.addr};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: ctrl/addr got %h expected %h", e.name, act, exp);

        // Remaining request fields follow from which port the bus address belongs to.
        fact = {p_bwr[k], p_bsz[k], p_bws[k], p_bwd[k]};
        if (e.addr == DADDR)      fexp = {1'b1, 2'd2, 4'hF, DWDAT};
        else if (e.addr == IADDR) fexp = {1'b0, 2'd2, 4'h0, 32'h0};
        else                      fexp = '0;
        n_checks++;
        if (fact[38:0] === fexp) n_pass++;
        else $display("FAIL %s: fields got %h expected %h", e.name, fact, fexp);

        if (e.oks[1] || e.oks[0]) begin
            rd_act = e.oks[1] ? p_ird[k] : p_drd[k];
            rd_exp = RDAT;
            n_checks++;
            if (rd_act === rd_exp) n_pass++;
            else $display("FAIL %s: rdata got %h expected %h", e.name, rd_act, rd_exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        resetn      = v.rst;
        inst_req    = v.ir;
        data_req    = v.dr;
        inst_cancel = v.cn;
        bus_addr_ok = v.ao;
        bus_data_ok = v.dk;
        bus_rdata   = v.dk ? RDAT : 32'h0;
        sb.push_back(v);
        #4;
        e = sb.pop_front();
        compare(e);
    endtask

    initial begin
        //                 name        rst ir dr cn ao dk rr  oks      breq addr   busy
        vecs.push_back(mk("rst_idle",  0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 0));
        vecs.push_back(mk("rst_out",   1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 0));
        // single inst read, zero-cycle address phase
        vecs.push_back(mk("i_aok",     1, 1, 0, 0, 1, 0, 0, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("i_wait",    1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 1));
        vecs.push_back(mk("i_dok",     1, 0, 0, 0, 0, 1, 0, 4'b0010, 0, 32'h0, 1));
        vecs.push_back(mk("i_idle",    1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 0));
        // fixed priority tie: data first, inst after the bubble
        vecs.push_back(mk("p_daok",    1, 1, 1, 0, 1, 0, 0, 4'b0100, 1, DADDR, 0));
        vecs.push_back(mk("p_dwait",   1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 1));
        vecs.push_back(mk("p_ddok",    1, 1, 0, 0, 0, 1, 0, 4'b0001, 0, 32'h0, 1));
        vecs.push_back(mk("p_iaok",    1, 1, 0, 0, 1, 0, 0, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("p_idok",    1, 0, 0, 0, 0, 1, 0, 4'b0010, 0, 32'h0, 1));
        vecs.push_back(mk("p_idle",    1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 0));
        // round-robin with both ports requesting continuously
        vecs.push_back(mk("rr_d1",     1, 1, 1, 0, 1, 0, 1, 4'b0100, 1, DADDR, 0));
        vecs.push_back(mk("rr_d1ok",   1, 1, 1, 0, 1, 1, 1, 4'b0001, 0, 32'h0, 1));
        vecs.push_back(mk("rr_i1",     1, 1, 1, 0, 1, 0, 1, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("rr_i1ok",   1, 1, 1, 0, 1, 1, 1, 4'b0010, 0, 32'h0, 1));
        vecs.push_back(mk("rr_d2",     1, 1, 1, 0, 1, 0, 1, 4'b0100, 1, DADDR, 0));
        vecs.push_back(mk("rr_d2ok",   1, 1, 1, 0, 1, 1, 1, 4'b0001, 0, 32'h0, 1));
        vecs.push_back(mk("rr_i2",     1, 1, 1, 0, 1, 0, 1, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("rr_i2ok",   1, 0, 0, 0, 0, 1, 1, 4'b0010, 0, 32'h0, 1));
        vecs.push_back(mk("rr_idle",   1, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 32'h0, 0));
        vecs.push_back(mk("rr_idle1",  1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 0));
        // delayed accept with cancel in the wait phase
        vecs.push_back(mk("c_req",     1, 1, 0, 0, 0, 0, 0, 4'b0000, 1, IADDR, 0));
        vecs.push_back(mk("c_w1",      1, 1, 0, 0, 0, 0, 0, 4'b0000, 1, IADDR, 1));
        vecs.push_back(mk("c_w2",      1, 1, 0, 1, 0, 0, 0, 4'b0000, 1, IADDR, 1));
        vecs.push_back(mk("c_aok",     1, 1, 0, 0, 1, 0, 0, 4'b1000, 1, IADDR, 1));
        vecs.push_back(mk("c_drop",    1, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 32'h0, 1));
        vecs.push_back(mk("c_next",    1, 1, 0, 0, 1, 0, 0, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("c_nextok",  1, 0, 0, 0, 0, 1, 0, 4'b0010, 0, 32'h0, 1));
        // cancel coincident with the inst response
        vecs.push_back(mk("cc_aok",    1, 1, 0, 0, 1, 0, 0, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("cc_dok",    1, 0, 0, 1, 0, 1, 0, 4'b0000, 0, 32'h0, 1));
        // cancel in the grant cycle itself
        vecs.push_back(mk("cg_aok",    1, 1, 0, 1, 1, 0, 0, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("cg_dok",    1, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 32'h0, 1));
        // cancel while data owns the bus has no effect
        vecs.push_back(mk("cd_aok",    1, 0, 1, 1, 1, 0, 0, 4'b0100, 1, DADDR, 0));
        vecs.push_back(mk("cd_dok",    1, 0, 0, 1, 0, 1, 0, 4'b0001, 0, 32'h0, 1));
        // reset in DATA, then a stray response
        vecs.push_back(mk("r_aok",     1, 1, 0, 0, 1, 0, 0, 4'b1000, 1, IADDR, 0));
        vecs.push_back(mk("r_rst",     0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 1));
        vecs.push_back(mk("r_late",    1, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 32'h0, 0));
        vecs.push_back(mk("r_idle",    1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 0));

        resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; inst_cancel = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i]);

        // Long address wait: a data request arriving mid-wait must not steal the grant.
        step(mk("lw_req", 1, 1, 0, 0, 0, 0, 0, 4'b0000, 1, IADDR, 0));
        for (int i = 0; i < 8; i++)
            step(mk("lw_hold", 1, 1, (i >= 2), 0, 0, 0, 0, 4'b0000, 1, IADDR, 1));
        step(mk("lw_aok",  1, 1, 1, 0, 1, 0, 0, 4'b1000, 1, IADDR, 1));
        step(mk("lw_dok",  1, 0, 1, 0, 0, 1, 0, 4'b0010, 0, 32'h0, 1));
        step(mk("lw_data", 1, 0, 1, 0, 1, 0, 0, 4'b0100, 1, DADDR, 0));
        step(mk("lw_ddok", 1, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 32'h0, 1));
        step(mk("lw_idle", 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
